// File: rtl/fir_decim.sv
// fir_decim: streaming FIR with optional decimation, FWFT input FIFO to output FIFO.
// One tap per cycle, each product dequantized with round-toward-zero division.
module fir_decim #(
  parameter int DECIMATION = 1,
  parameter int TAPS = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic signed [0:TAPS-1][DATA_WIDTH-1:0] coeff = '0,
  parameter int QUANT_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full
);
  localparam int AW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam logic [1:0] S_LOAD = 2'd0, S_MAC = 2'd1, S_WRITE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, tap;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d, prod, bias;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [DATA_WIDTH-1:0] x_q [TAPS];
  logic [DATA_WIDTH-1:0] x_d [TAPS];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    y_d = y_q;
    x_d = x_q;
    x_in_rd_en = rst && state_q == S_LOAD && !x_in_empty;
    y_out_wr_en = state_q == S_WRITE && !y_out_full;
    tap = AW'(TAPS - 1) - cnt_q;
    prod = $signed(coeff[tap]) * $signed(x_q[cnt_q]);
    // biasing negatives by 2^Q-1 turns the arithmetic shift into truncation toward zero
    bias = prod[DATA_WIDTH-1] ? DATA_WIDTH'((1 << QUANT_BITS) - 1) : '0;
    if (x_in_rd_en) begin
      for (int j = TAPS - 1; j > 0; j--) x_d[j] = x_q[j-1];
      x_d[0] = x_in;
      cnt_d = cnt_q == AW'(DECIMATION - 1) ? '0 : cnt_q + 1'b1;
      acc_d = cnt_q == AW'(DECIMATION - 1) ? '0 : acc_q;
      state_d = cnt_q == AW'(DECIMATION - 1) ? S_MAC : S_LOAD;
    end
    if (state_q == S_MAC) begin
      acc_d = acc_q + ((prod + bias) >>> QUANT_BITS);
      cnt_d = cnt_q == AW'(TAPS - 1) ? '0 : cnt_q + 1'b1;
      y_d = cnt_q == AW'(TAPS - 1) ? acc_d : y_q;
      state_d = cnt_q == AW'(TAPS - 1) ? S_WRITE : S_MAC;
    end
    if (y_out_wr_en) state_d = S_LOAD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      cnt_q <= '0;
      acc_q <= '0;
      y_q <= '0;
      x_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      y_q <= y_d;
      x_q <= x_d;
    end
  end
  assign y_out = y_q;
endmodule

// File: tb/tb_fir_decim.sv
// tb_fir_decim: directed and random checks of fir_decim (DECIMATION 1 and 8) against a convolution model.
module tb_fir_decim;
  localparam int TAPS = 32;
  localparam int C [TAPS] = '{0, 0, -4, -7, -2, 8, 12, 2, 3, 30, 48, -4, -116, -168, -61, 138,
                              138, -61, -168, -116, -4, 48, 30, 3, 2, 12, 8, -2, -7, -4, 0, 0};
  function automatic logic [0:TAPS-1][31:0] pack_c();
    logic [0:TAPS-1][31:0] r;
    for (int i = 0; i < TAPS; i++) r[i] = C[i];
    return r;
  endfunction
  localparam logic [0:TAPS-1][31:0] CP = pack_c();

  logic clk = 0, rst = 0;
  logic gap1 = 0, gap8 = 0, rf1 = 0, rf8 = 0, ff1 = 0, ff8 = 0, rand_en = 0;
  int n1 = 0, n8 = 0, p1, p8, oc1, oc8, viol = 0, checks = 0, errors = 0;
  int samp [128];
  logic [31:0] o1 [128];
  logic [31:0] o8 [128];
  logic rd1, rd8, emp1, emp8, wr1, wr8, full1, full8;
  logic [31:0] x1, x8, y1, y8, snap;

  always #5 clk = ~clk;
  assign emp1 = p1 >= n1 || gap1;
  assign emp8 = p8 >= n8 || gap8;
  assign full1 = ff1 | rf1;
  assign full8 = ff8 | rf8;
  assign x1 = samp[p1];
  assign x8 = samp[p8];

  fir_decim #(.DECIMATION(1), .TAPS(TAPS), .DATA_WIDTH(32), .coeff(CP), .QUANT_BITS(10)) d1 (
    .clk(clk), .rst(rst), .x_in_rd_en(rd1), .x_in_empty(emp1), .x_in(x1),
    .y_out(y1), .y_out_wr_en(wr1), .y_out_full(full1));
  fir_decim #(.DECIMATION(8), .TAPS(TAPS), .DATA_WIDTH(32), .coeff(CP), .QUANT_BITS(10)) d8 (
    .clk(clk), .rst(rst), .x_in_rd_en(rd8), .x_in_empty(emp8), .x_in(x8),
    .y_out(y8), .y_out_wr_en(wr8), .y_out_full(full8));

  // FIFO models: pop pointers and captured outputs
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1 <= 0; p8 <= 0; oc1 <= 0; oc8 <= 0;
    end else begin
      if (rd1) p1 <= p1 + 1;
      if (rd8) p8 <= p8 + 1;
      if (wr1) begin if (oc1 < 128) o1[oc1] <= y1; oc1 <= oc1 + 1; end
      if (wr8) begin if (oc8 < 128) o8[oc8] <= y8; oc8 <= oc8 + 1; end
    end
  end
  always @(posedge clk)
    if ((rd1 && emp1) || (wr1 && full1) || (rd1 && wr1) || (rd8 && emp8) || (wr8 && full8) || (rd8 && wr8))
      viol <= viol + 1;
  always @(negedge clk) begin
    gap1 <= rand_en && $urandom_range(0, 3) == 0;
    gap8 <= rand_en && $urandom_range(0, 3) == 0;
    rf1 <= rand_en && $urandom_range(0, 3) == 0;
    rf8 <= rand_en && $urandom_range(0, 3) == 0;
  end

  // output k sees the window whose newest sample is index (k+1)*d-1; older-than-start samples are 0
  function automatic int ref_y(int k, int d);
    int n, s, acc;
    n = (k + 1) * d - 1;
    acc = 0;
    for (int j = 0; j < TAPS; j++) begin
      s = n - j >= 0 ? samp[n - j] : 0;
      acc += (C[TAPS - 1 - j] * s) / 1024;
    end
    return acc;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rand_en = 0; ff1 = 0; ff8 = 0; rst = 0;
    #1;
    chk("rst_y1", y1, 0);
    chk("rst_wr1", {31'b0, wr1}, 0);
    chk("rst_rd1", {31'b0, rd1}, 0);
    chk("rst_y8", y8, 0);
    n1 = 0; n8 = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic finish_test(string name, int ns);
    int c;
    c = 0;
    while (!(oc1 >= ns && oc8 >= ns / 8) && c < 8000) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    chk($sformatf("%s_count1", name), oc1, ns);
    chk($sformatf("%s_count8", name), oc8, ns / 8);
    for (int k = 0; k < ns && k < oc1; k++) chk($sformatf("%s_d1_y%0d", name, k), o1[k], ref_y(k, 1));
    for (int k = 0; k < ns / 8 && k < oc8; k++) chk($sformatf("%s_d8_y%0d", name, k), o8[k], ref_y(k, 8));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) samp[i] = 0;
    samp[0] = 1024;
    n1 = 41; n8 = 41;
    do_reset();
    samp[0] = 1024;
    n1 = 41; n8 = 41;
    finish_test("imp", 41);
    chk("imp_y2", o1[2], -4);
    chk("imp_y13", o1[13], -168);
    chk("imp_y16", o1[16], 138);
    chk("imp_y33", o1[33], 0);
    chk("imp8_y0", o8[0], 2);

    do_reset();
    samp[0] = 1;
    n1 = 40; n8 = 40;
    finish_test("imp1", 40);
    chk("imp1_y9", o1[9], 0);

    do_reset();
    samp[0] = -1024;
    n1 = 40; n8 = 40;
    finish_test("impn", 40);
    chk("impn_y9", o1[9], -30);
    chk("impn_y13", o1[13], 168);

    do_reset();
    for (int i = 0; i < 64; i++) samp[i] = 1024;
    n1 = 64; n8 = 64;
    finish_test("step", 64);
    chk("step_y40", o1[40], -242);
    chk("step_y63", o1[63], -242);
    chk("step8_y7", o8[7], -242);

    do_reset();
    for (int i = 0; i < 80; i++) samp[i] = i % 2 ? int'($urandom_range(0, 8191)) - 4096 : int'($urandom);
    rand_en = 1;
    n1 = 80; n8 = 80;
    finish_test("rand", 80);

    do_reset();
    for (int i = 0; i < 24; i++) samp[i] = int'($urandom_range(0, 1 << 20)) - (1 << 19);
    ff1 = 1;
    n1 = 24; n8 = 24;
    repeat (40) @(negedge clk);
    chk("bp_none", oc1, 0);
    snap = y1;
    chk("bp_first", snap, ref_y(0, 1));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk($sformatf("bp_wr_%0d", c), {31'b0, wr1}, 0);
      chk($sformatf("bp_rd_%0d", c), {31'b0, rd1}, 0);
      chk($sformatf("bp_y_%0d", c), y1, snap);
    end
    ff1 = 0;
    #1;
    chk("bp_release_wr", {31'b0, wr1}, 1);
    @(negedge clk);
    chk("bp_one_write", oc1, 1);
    chk("bp_wr_drop", {31'b0, wr1}, 0);
    finish_test("bp", 24);

    do_reset();
    for (int i = 0; i < 4; i++) samp[i] = int'($urandom);
    n1 = 4; n8 = 4;
    repeat (10) @(negedge clk);
    chk("mid_none", oc1, 0);
    rst = 0; n1 = 0; n8 = 0;
    #1;
    chk("mid_wr", {31'b0, wr1}, 0);
    chk("mid_y", y1, 0);
    @(negedge clk);
    chk("mid_count", oc1, 0);
    for (int i = 0; i < 40; i++) samp[i] = int'($urandom_range(0, 1 << 16)) - (1 << 15);
    rst = 1;
    n1 = 40; n8 = 40;
    finish_test("post_rst", 40);

    chk("protocol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
- Streaming fixed-point FIR filter with optional decimation, for the FM-radio datapath.
- Reads samples from an upstream first-word-fall-through FIFO.
- Convolves them with a compile-time coefficient set quantized at 2^10 and writes one result per DECIMATION inputs to a downstream FIFO.
- Results are bit-exact with the team's C reference model, including per-product dequantization.

Parameters:
- DECIMATION, 1: input samples consumed per output sample (>=1, <=TAPS).
- TAPS, 32: number of filter taps.
- DATA_WIDTH, 32: sample, coefficient and result width (signed two's complement).
- coeff, all zeros: packed signed array [0:TAPS-1][DATA_WIDTH-1:0]; coeff[0] is the first listed.
- QUANT_BITS, 10: dequantization shift; the scale is 2^QUANT_BITS = 1024.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- x_in_rd_en  out  1  pop request to input FIFO.
- x_in_empty  in  1  input FIFO empty.
- x_in  in  DATA_WIDTH  input FIFO head data, valid whenever x_in_empty=0.
- y_out  out  DATA_WIDTH  filtered sample.
- y_out_wr_en  out  1  push strobe to output FIFO.
- y_out_full  in  1  output FIFO full.

Behaviour:
- Reset (rst=0, async): shift register x[0..TAPS-1], accumulator and counters all clear to 0; state S_LOAD; y_out=0, y_out_wr_en=0, x_in_rd_en=0.
- S_LOAD:
  - x_in_rd_en = !x_in_empty (combinational).
  - On each pop: x[j] <= x[j-1] for j>=1, and x[0] <= x_in, so x[0] is always the newest sample.
  - After DECIMATION pops: clear the accumulator and go to S_MAC.
  - Empty input stalls in S_LOAD with no state change.
- S_MAC: one tap per cycle, j = 0..TAPS-1, computing acc += dq(coeff[TAPS-1-j] * x[j]).
  - The product is truncated to its low DATA_WIDTH bits, matching C int overflow.
  - dq(p) = p / 2^QUANT_BITS, with signed division truncating toward zero (not an arithmetic shift). Example: dq(-4) = 0 and dq(-1500) = -1.
  - The accumulator wraps modulo 2^DATA_WIDTH.
  - After TAPS cycles: y_out <= acc, then go to S_WRITE.
- S_WRITE:
  - y_out_wr_en = !y_out_full (combinational); y_out holds stable.
  - On the write cycle go to S_LOAD.
  - While full: stall, y_out_wr_en=0, no input popped.
- No input is consumed outside S_LOAD. The shift register persists across outputs and is never flushed except by reset.
- Throughput: one output per DECIMATION+TAPS+1 cycles minimum (DECIMATION=1, TAPS=32: 34 cycles).
- No simultaneous pop and push (state exclusive).
- Reset mid-operation aborts the current output: y_out_wr_en drops immediately, the partial accumulation is discarded, and the shift register is zeroed.
- x_in_rd_en and y_out_wr_en are never asserted while x_in_empty=1 or y_out_full=1 respectively.

Test Plan:
- Impulse, DECIMATION=1, default 32-tap set (coeff = 0,0,-4,-7,-2,8,12,2,3,30,48,-4,-116,-168,-61,138, then mirrored): input 1024 followed by 40 zeros -> outputs 0,0,-4,-7,-2,8,12,2,3,30,48,-4,-116,-168,-61,138,138,-61,... then zeros from output 33 onward.
- Truncation: impulse of value 1 -> all outputs 0. Impulse of -1024 -> outputs equal the negated coefficients.
- Step: constant 1024 for 64 samples -> outputs ramp, then hold -242 from output 32 onward.
- Backpressure: hold y_out_full=1 for 100 cycles after the first result -> y_out_wr_en stays 0, y_out stable, x_in_rd_en stays 0. On release, exactly one write occurs, the sequence continues and no samples are lost.
- Decimation: DECIMATION=8, TAPS=32, 64 impulse/step samples -> exactly 8 outputs, matching the C model computed on every 8th shifted window.
- Empty stall / reset: gaps on the input FIFO produce identical output values. Asserting rst low during S_MAC yields no write, and the next output matches a fresh-start computation.
